ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Sequencing controller between the core's load/store stage and the on-chip word RAM wrapper; drives that RAM's address, store-data and write-enable lines and consumes its load data.
- The RAM is word-wide only (no byte enables) with 1-cycle read latency.
- This block performs all RV32 load/store sizes, using read-modify-write for SB/SH.
- It also sign/zero-extends loads and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 14, RAM word-address width; RAM depth = 2^ADDR_W words.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- req  input  1  access request; held high until done observed
- wen  input  1  1 = store, 0 = load
- addr  input  32  byte address
- size  input  2  00 byte, 01 half, 10 word, 11 illegal
- load_unsigned  input  1  zero-extend sub-word loads (LBU/LHU)
- wdata  input  32  store data, right-justified
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; misaligned or illegal size
- rdata  output  32  extended load result; valid with done, held until next done
- ram_addr  output  ADDR_W  word address to RAM
- ram_store  output  32  write data to RAM
- ram_wen  output  1  RAM write enable
- ram_load  input  32  RAM read data; valid the cycle after ram_addr is presented with ram_wen=0

Behaviour:
- Reset values (asynchronous): state IDLE; busy=0, done=0, err=0; rdata=0; ram_addr=0; ram_store=0; ram_wen=0; internal latches=0.
- FSM states: IDLE, RD, RDW, WR, DONE.
- IDLE: req is sampled only here. On req=1, latch wen/addr/size/load_unsigned/wdata, then:
  - illegal: size=11, or half with addr[0]=1, or word with addr[1:0]!=0 -> DONE with err=1; no RAM access.
  - word store -> WR.
  - any load, or SB/SH -> RD.
- RD: ram_addr=latched addr[ADDR_W+1:2], ram_wen=0 -> RDW.
- RDW: capture ram_load into a word buffer.
  - Load: extract lane, extend, write rdata -> DONE.
  - SB/SH: -> WR.
- WR: ram_wen=1.
  - ram_store = wdata for SW.
  - For SB/SH, ram_store = buffer with the byte/half at addr[1:0] replaced by wdata[7:0]/wdata[15:0]; other lanes unchanged.
  - Next state DONE.
- DONE: done=1, err=0 unless set by the illegal path -> IDLE.
- Latency from accepting edge to done high: illegal 1, SW 2, load 3, SB/SH 4 cycles.
- Lanes are little-endian. Byte lane = addr[1:0]; half lane = addr[1].
  - Signed loads replicate bit 7/15.
  - load_unsigned is ignored for word loads.
- Address bits above ADDR_W+1 are ignored, so the address aliases within RAM depth; no range error.
- ram_wen is high only in WR, for exactly one cycle per store. It is never high for loads or errors.
- ram_addr and ram_store hold their last value outside RD/WR.
- Request input changes after acceptance are ignored until IDLE.
- Handshake: the requester drops req on the edge where it samples done=1. A req still high in the following IDLE cycle is a new request (back-to-back allowed; one idle cycle between accesses).
- rdata is unchanged by stores and by errors.
- Reset asserted mid-operation, including WR: state returns to IDLE and ram_wen drops immediately; no partial write may occur at the next edge; the pending request is discarded without done.

Test Plan:
- Reset: hold nRST=0 -> all outputs 0, busy=0. Release; req=0 for 5 cycles -> ram_wen never 1.
- SW then LW: SW addr=0x10 wdata=0xDEADBEEF -> done 2 cycles after accept, ram_addr=4, ram_wen for one cycle. LW addr=0x10 -> done after 3 cycles, rdata=0xDEADBEEF, err=0.
- RMW store: SB addr=0x12 wdata=0x000000A5 over word 0xDEADBEEF -> one write of 0xDEA5BEEF, done after 4 cycles. SH addr=0x10 wdata=0x1234 -> word 0xDEA51234.
- Load extension on word 0x80FF7F01:
  - LB addr+3 -> 0xFFFFFF80
  - LBU addr+3 -> 0x00000080
  - LH addr+2 -> 0xFFFF80FF
  - LHU addr+0 -> 0x00007F01
- Errors: LW addr=0x02, SH addr=0x03, size=11 -> done after 1 cycle with err=1, ram_wen=0, RAM contents and rdata unchanged.
- Reset mid-RMW: pull nRST low during WR of an SB -> ram_wen drops, no done. A later LW of the same word returns the original contents.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// Bus bundle between the load/store stage, the access controller
// and the word-wide on-chip RAM wrapper.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              req;
    logic              wen;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic              load_unsigned;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_store;
    logic              ram_wen;
    logic [31:0]       ram_load;

    modport slave (
        input  req, wen, addr, size, load_unsigned, wdata, ram_load,
        output busy, done, err, rdata, ram_addr, ram_store, ram_wen
    );

    modport master (
        output req, wen, addr, size, load_unsigned, wdata, ram_load,
        input  busy, done, err, rdata, ram_addr, ram_store, ram_wen
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// RV32 load/store sequencer for a word-only RAM with 1-cycle read latency.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module ram_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic               CLK,
    input  logic               nRST,
    ram_access_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_wen;
    logic [1:0]        r_lane;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [15:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_store;
    logic              r_ram_wen;

    logic              w_illegal;
    logic              w_accept;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    assign w_accept = (r_state == IDLE) && bus.req;

    // Classify the incoming request: bad size or misaligned half/word
    always_comb begin
        w_illegal = 1'b0;
        unique case (bus.size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = bus.addr[0];
            2'b10:   w_illegal = (bus.addr[1:0] != 2'b00);
            default: w_illegal = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the RAM read word
    always_comb begin
        w_byte = bus.ram_load[{r_lane, 3'b000} +: 8];
        w_half = bus.ram_load[{r_lane[1], 4'b0000} +: 16];
        w_ext  = bus.ram_load;
        unique case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = bus.ram_load;
        endcase
    end

    // Merge the store byte/half into the word just read back
    always_comb begin
        w_merge = bus.ram_load;
        if (r_size == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.req) begin
                    if (w_illegal) begin
                        w_next = DONE;
                    end else if (bus.wen && bus.size == 2'b10) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = RDW;
            RDW:     w_next = r_wen ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latches, RAM drive registers and load result
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wen       <= 1'b0;
            r_lane      <= 2'b00;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_ram_wen   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wen   <= bus.wen;
                        r_lane  <= bus.addr[1:0];
                        r_size  <= bus.size;
                        r_uns   <= bus.load_unsigned;
                        r_wdata <= bus.wdata[15:0];
                        r_err   <= w_illegal;
                        if (!w_illegal) begin
                            r_ram_addr <= bus.addr[ADDR_W+1:2];
                            if (bus.wen && bus.size == 2'b10) begin
                                r_ram_store <= bus.wdata;
                                r_ram_wen   <= 1'b1;
                            end
                        end
                    end
                end
                RDW: begin
                    if (r_wen) begin
                        r_ram_store <= w_merge;
                        r_ram_wen   <= 1'b1;
                    end else begin
                        r_rdata <= w_ext;
                    end
                end
                WR: begin
                    r_ram_wen <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.err       = (r_state == DONE) && r_err;
    assign bus.rdata     = r_rdata;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_store = r_ram_store;
    assign bus.ram_wen   = r_ram_wen;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural 1-cycle RAM.
// Driver pushes expected responses; a negedge monitor checks each done.
module tb_ram_access_ctrl;
    localparam int ADDR_W = 14;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        logic [31:0] wdat;
        logic [31:0] waddr;
    } exp_t;

    logic CLK;
    logic nRST;
    int   n_chk;
    int   n_pass;
    int   busy_cnt;
    int   wr_cnt;
    logic [31:0] wr_dat;
    logic [31:0] wr_adr;
    exp_t q[$];

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    ram_access_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

    ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: word write, registered read
    always @(posedge CLK) begin
        if (bif.ram_wen) mem[bif.ram_addr] <= bif.ram_store;
        bif.ram_load <= mem[bif.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: compare every done against the scoreboard head
    always @(negedge CLK) begin
        exp_t e;
        if (!nRST) begin
            busy_cnt = 0;
            wr_cnt   = 0;
        end else begin
            if (bif.busy) busy_cnt++;
            if (bif.ram_wen) begin
                wr_cnt++;
                wr_dat = bif.ram_store;
                wr_adr = 32'(bif.ram_addr);
            end
            if (bif.done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "/err"}, 32'(bif.err), 32'(e.err));
                    chk({e.name, "/rdata"}, bif.rdata, e.rdata);
                    chk({e.name, "/lat"}, busy_cnt, e.lat);
                    chk({e.name, "/nwr"}, wr_cnt, e.nwr);
                    if (e.nwr > 0) begin
                        chk({e.name, "/wdat"}, wr_dat, e.wdat);
                        chk({e.name, "/waddr"}, wr_adr, e.waddr);
                    end
                end
                busy_cnt = 0;
                wr_cnt   = 0;
            end
        end
    end

    task automatic op(input string nm, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic u,
                      input logic [31:0] d, input logic e_err,
                      input logic [31:0] e_rd, input int e_lat,
                      input int e_nwr, input logic [31:0] e_wd);
        exp_t e;
        int   n;
        @(negedge CLK);
        bif.wen           = w;
        bif.addr          = a;
        bif.size          = s;
        bif.load_unsigned = u;
        bif.wdata         = d;
        bif.req           = 1'b1;
        e.name  = nm;
        e.err   = e_err;
        e.rdata = e_rd;
        e.lat   = e_lat;
        e.nwr   = e_nwr;
        e.wdat  = e_wd;
        e.waddr = {18'd0, a[15:2]};
        q.push_back(e);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bif.done && n < 20);
        if (!bif.done) chk({nm, "/timeout"}, 32'(n), 32'(e_lat));
        bif.req = 1'b0;
    endtask

    initial begin
        int n;
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
        nRST              = 1'b0;
        bif.req           = 1'b0;
        bif.wen           = 1'b0;
        bif.addr          = '0;
        bif.size          = '0;
        bif.load_unsigned = 1'b0;
        bif.wdata         = '0;
        repeat (3) @(negedge CLK);
        chk("rst/busy", 32'(bif.busy), 0);
        chk("rst/done", 32'(bif.done), 0);
        chk("rst/err", 32'(bif.err), 0);
        chk("rst/rdata", bif.rdata, 0);
        chk("rst/ram_addr", 32'(bif.ram_addr), 0);
        chk("rst/ram_store", bif.ram_store, 0);
        chk("rst/ram_wen", 32'(bif.ram_wen), 0);
        nRST = 1'b1;
        repeat (5) @(negedge CLK);
        chk("idle/wen_cnt", 32'(wr_cnt), 0);

        op("SW10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 2, 1, 32'hDEADBEEF);
        op("LW10", 0, 32'h10, 2'b10, 0, 0, 0, 32'hDEADBEEF, 3, 0, 0);
        op("SB12", 1, 32'h12, 2'b00, 0, 32'h000000A5, 0, 32'hDEADBEEF, 4, 1, 32'hDEA5BEEF);
        op("SH10", 1, 32'h10, 2'b01, 0, 32'h00001234, 0, 32'hDEADBEEF, 4, 1, 32'hDEA51234);
        op("LW10b", 0, 32'h10, 2'b10, 1, 0, 0, 32'hDEA51234, 3, 0, 0);
        op("SW20", 1, 32'h20, 2'b10, 0, 32'h80FF7F01, 0, 32'hDEA51234, 2, 1, 32'h80FF7F01);
        op("LB23", 0, 32'h23, 2'b00, 0, 0, 0, 32'hFFFFFF80, 3, 0, 0);
        op("LBU23", 0, 32'h23, 2'b00, 1, 0, 0, 32'h00000080, 3, 0, 0);
        op("LH22", 0, 32'h22, 2'b01, 0, 0, 0, 32'hFFFF80FF, 3, 0, 0);
        op("LHU20", 0, 32'h20, 2'b01, 1, 0, 0, 32'h00007F01, 3, 0, 0);
        op("LB20", 0, 32'h20, 2'b00, 0, 0, 0, 32'h00000001, 3, 0, 0);
        op("LB22", 0, 32'h22, 2'b00, 0, 0, 0, 32'hFFFFFFFF, 3, 0, 0);
        op("LW02", 0, 32'h02, 2'b10, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0);
        op("SH03", 1, 32'h03, 2'b01, 0, 32'h5555, 1, 32'hFFFFFFFF, 1, 0, 0);
        op("SZ11", 1, 32'h20, 2'b11, 0, 32'h5555, 1, 32'hFFFFFFFF, 1, 0, 0);
        op("LW20", 0, 32'h20, 2'b10, 0, 0, 0, 32'h80FF7F01, 3, 0, 0);
        op("LWalias", 0, 32'h10010, 2'b10, 0, 0, 0, 32'hDEA51234, 3, 0, 0);

        @(negedge CLK);
        bif.wen   = 1'b1;
        bif.addr  = 32'h11;
        bif.size  = 2'b00;
        bif.wdata = 32'h000000FF;
        bif.req   = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bif.ram_wen && n < 20);
        chk("rstwr/reached_wr", 32'(bif.ram_wen), 1);
        nRST = 1'b0;
        #1;
        chk("rstwr/ram_wen", 32'(bif.ram_wen), 0);
        chk("rstwr/busy", 32'(bif.busy), 0);
        chk("rstwr/done", 32'(bif.done), 0);
        bif.req = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        op("LWpost", 0, 32'h10, 2'b10, 0, 0, 0, 32'hDEA51234, 3, 0, 0);

        repeat (3) @(negedge CLK);
        chk("queue_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
